// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin front end for a single-command SDRAM controller.
// Accepts one host request at a time, issues it, and routes read data back to its owner.
module sdram_port_arbiter #(
    parameter int HADDR_WIDTH = 24,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [HADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]  p0_wdata,
    output logic                   p0_gnt,
    output logic [DATA_WIDTH-1:0]  p0_rdata,
    output logic                   p0_rvalid,

    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [HADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]  p1_wdata,
    output logic                   p1_gnt,
    output logic [DATA_WIDTH-1:0]  p1_rdata,
    output logic                   p1_rvalid,

    output logic [HADDR_WIDTH-1:0] wr_addr,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_enable,
    output logic                   rd_enable,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_ready,
    input  logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE
    } state_t;

    state_t                 state;
    logic                   last_p0;
    logic                   owner;
    logic                   cur_we;
    logic                   rd_pending;
    logic                   rd_done;
    logic [HADDR_WIDTH-1:0] cmd_addr;

    logic                   pick_p1;
    logic                   sel_we;
    logic [HADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   rd_return;

    // p1 wins when it is the only requester, or when both ask and p0 went last.
    always_comb begin
        pick_p1   = p1_req && (!p0_req || last_p0);
        sel_we    = pick_p1 ? p1_we    : p0_we;
        sel_addr  = pick_p1 ? p1_addr  : p0_addr;
        sel_wdata = pick_p1 ? p1_wdata : p0_wdata;
        rd_return = rd_pending && rd_ready;
    end

    assign wr_addr = cmd_addr;
    assign rd_addr = cmd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_p0    <= 1'b0;
            owner      <= 1'b0;
            cur_we     <= 1'b0;
            rd_pending <= 1'b0;
            rd_done    <= 1'b0;
            cmd_addr   <= '0;
            wr_data    <= '0;
            wr_enable  <= 1'b0;
            rd_enable  <= 1'b0;
            p0_gnt     <= 1'b0;
            p1_gnt     <= 1'b0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;

            // Read data may come back while still in ISSUE or during the busy phase.
            if (rd_return) begin
                if (owner) begin
                    p1_rdata  <= rd_data;
                    p1_rvalid <= 1'b1;
                end else begin
                    p0_rdata  <= rd_data;
                    p0_rvalid <= 1'b1;
                end
                rd_pending <= 1'b0;
                rd_done    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        owner      <= pick_p1;
                        last_p0    <= !pick_p1;
                        cur_we     <= sel_we;
                        cmd_addr   <= sel_addr;
                        wr_data    <= sel_wdata;
                        wr_enable  <= sel_we;
                        rd_enable  <= !sel_we;
                        rd_pending <= !sel_we;
                        rd_done    <= 1'b0;
                        p0_gnt     <= !pick_p1;
                        p1_gnt     <= pick_p1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (busy) begin
                        wr_enable <= 1'b0;
                        rd_enable <= 1'b0;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!busy && (cur_we || rd_done || rd_return)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: requester queues, a controller model and a
// transaction-level scoreboard checked on every clock.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_enable, rd_enable;
    logic [DW-1:0] rd_data = '0;
    logic          rd_ready = 1'b0;
    logic          busy = 1'b0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
        .wr_enable(wr_enable), .rd_enable(rd_enable),
        .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    txn_t q0[$];
    txn_t q1[$];

    // Controller model knobs, owned by the main sequence.
    int            stall_cycles = 0;
    int            busy_len = 3;
    int            rd_at = 2;
    logic [DW-1:0] ret_data = '0;

    // Owned by the controller model.
    bit ctrl_run = 0;
    int cmds_accepted = 0;
    int rd_pulses = 0;

    // Owned by the scoreboard.
    bit            cmd_active = 0;
    int            gnt_cnt[2];
    int            rvalid_cnt[2];
    int            wr_en_cycles = 0;
    int            rd_en_cycles = 0;
    int            gnt_log[$];
    logic [AW-1:0] seen_wr_addr = '0;
    logic [DW-1:0] seen_wr_data = '0;

    function automatic txn_t mk(logic we, logic [AW-1:0] addr, logic [DW-1:0] data);
        txn_t t;
        t.we = we;
        t.addr = addr;
        t.wdata = data;
        return t;
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(string tag);
        check_output({tag, "_strobes"},
                     {26'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, wr_enable, rd_enable}, 32'd0);
        check_output({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_output({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_output({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check_output({tag, "_p0_rdata"}, 32'(p0_rdata), 32'd0);
        check_output({tag, "_p1_rdata"}, 32'(p1_rdata), 32'd0);
    endtask

    // Requesters: present the head of each queue until it is granted.
    initial begin
        forever begin
            @(negedge clk);
            if (p0_gnt && q0.size() > 0) void'(q0.pop_front());
            if (p1_gnt && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                p0_req = 1'b1; p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata;
            end else begin
                p0_req = 1'b0;
            end
            if (q1.size() > 0) begin
                p1_req = 1'b1; p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata;
            end else begin
                p1_req = 1'b0;
            end
        end
    end

    // Controller: optional refresh stall with busy low, then a busy window,
    // with read data returned at a chosen cycle inside it.
    initial begin
        int  k;
        bit  is_read;
        k = 0;
        is_read = 0;
        forever begin
            @(negedge clk);
            if (!ctrl_run && (wr_enable || rd_enable)) begin
                ctrl_run = 1;
                k = 0;
                is_read = rd_enable;
                cmds_accepted++;
            end
            if (ctrl_run) begin
                busy = (k >= stall_cycles) && (k < stall_cycles + busy_len);
                rd_ready = is_read && (k == stall_cycles + rd_at - 1);
                rd_data = rd_ready ? ret_data : 16'hDEAD;
                if (rd_ready) rd_pulses++;
                if (k == stall_cycles + busy_len) ctrl_run = 0;
                k++;
            end else begin
                busy = 1'b0;
                rd_ready = 1'b0;
                rd_data = 16'hDEAD;
            end
        end
    end

    // Scoreboard: predicts grants, commands and read returns at transaction level.
    initial begin
        int            last_owner;
        int            w;
        int            en_cnt;
        bit            en_prev, gnt_prev, ctrl_prev, read_out, exp_v0, exp_v1;
        int            read_owner;
        txn_t          cur;
        logic [DW-1:0] exp_rdata[2];
        last_owner = 1; en_cnt = 0; en_prev = 0; gnt_prev = 0; ctrl_prev = 0;
        read_out = 0; read_owner = 0; cur = '0; exp_rdata[0] = '0; exp_rdata[1] = '0;
        gnt_cnt[0] = 0; gnt_cnt[1] = 0; rvalid_cnt[0] = 0; rvalid_cnt[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check_all_zero("in_reset");
                last_owner = 1; read_out = 0; cmd_active = 0; en_cnt = 0;
                en_prev = 0; gnt_prev = 0; exp_rdata[0] = '0; exp_rdata[1] = '0;
                ctrl_prev = ctrl_run;
            end else begin
                if (ctrl_prev && !ctrl_run) cmd_active = 0;
                ctrl_prev = ctrl_run;

                check_output("enable_exclusive", {31'd0, wr_enable & rd_enable}, 32'd0);

                if (p0_gnt || p1_gnt) begin
                    if (p0_req && p1_req) w = 1 - last_owner;
                    else w = p1_req ? 1 : 0;
                    check_output("gnt_winner", {30'd0, p0_gnt, p1_gnt}, (w == 1) ? 32'd1 : 32'd2);
                    check_output("gnt_one_cycle", {31'd0, gnt_prev}, 32'd0);
                    check_output("gnt_while_busy", {31'd0, cmd_active}, 32'd0);
                    if (w == 1) begin
                        check_output("gnt_has_req_p1", q1.size(), (q1.size() > 0) ? q1.size() : 1);
                        if (q1.size() > 0) cur = q1[0];
                    end else begin
                        check_output("gnt_has_req_p0", q0.size(), (q0.size() > 0) ? q0.size() : 1);
                        if (q0.size() > 0) cur = q0[0];
                    end
                    cmd_active = 1;
                    last_owner = w;
                    gnt_log.push_back(w);
                    read_out = !cur.we;
                    read_owner = w;
                end
                if (p0_gnt) gnt_cnt[0]++;
                if (p1_gnt) gnt_cnt[1]++;
                gnt_prev = p0_gnt | p1_gnt;

                if (wr_enable || rd_enable) begin
                    check_output("enable_type", {30'd0, wr_enable, rd_enable},
                                 cur.we ? 32'd2 : 32'd1);
                    check_output("enable_owned", {31'd0, cmd_active}, 32'd1);
                    check_output("cmd_wr_addr", 32'(wr_addr), 32'(cur.addr));
                    check_output("cmd_rd_addr", 32'(rd_addr), 32'(cur.addr));
                    check_output("cmd_wr_data", 32'(wr_data), 32'(cur.wdata));
                    en_cnt++;
                    if (wr_enable) begin
                        wr_en_cycles++;
                        seen_wr_addr = wr_addr;
                        seen_wr_data = wr_data;
                    end
                    if (rd_enable) rd_en_cycles++;
                end else if (en_prev) begin
                    check_output("enable_cycles", en_cnt, stall_cycles + 1);
                    en_cnt = 0;
                end
                en_prev = wr_enable | rd_enable;

                exp_v0 = rd_ready && read_out && (read_owner == 0);
                exp_v1 = rd_ready && read_out && (read_owner == 1);
                if (exp_v0) exp_rdata[0] = rd_data;
                if (exp_v1) exp_rdata[1] = rd_data;
                if (exp_v0 || exp_v1) read_out = 0;
                check_output("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, exp_v0});
                check_output("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, exp_v1});
                check_output("p0_rdata", 32'(p0_rdata), 32'(exp_rdata[0]));
                check_output("p1_rdata", 32'(p1_rdata), 32'(exp_rdata[1]));
                if (p0_rvalid) rvalid_cnt[0]++;
                if (p1_rvalid) rvalid_cnt[1]++;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(string name, int budget);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (n < budget && !done) begin
            @(posedge clk);
            #2;
            done = (q0.size() == 0) && (q1.size() == 0) && !cmd_active && !ctrl_run;
            n++;
        end
        check_output({name, "_completes"}, {31'd0, done}, 32'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic apply_stimulus();
        int g0, g1, v0, v1, we0, re0, acc, logb, rp, n;
        bit saw;
        int exp_order[6];
        exp_order = '{0, 1, 0, 1, 0, 1};

        apply_reset();

        // Single write from p0.
        g0 = gnt_cnt[0]; g1 = gnt_cnt[1]; we0 = wr_en_cycles; re0 = rd_en_cycles;
        @(posedge clk);
        q0.push_back(mk(1'b1, 24'h000123, 16'hBEEF));
        wait_done("write", 100);
        check_output("write_p0_gnts", gnt_cnt[0] - g0, 32'd1);
        check_output("write_p1_gnts", gnt_cnt[1] - g1, 32'd0);
        check_output("write_wr_cycles", wr_en_cycles - we0, 32'd1);
        check_output("write_rd_cycles", rd_en_cycles - re0, 32'd0);
        check_output("write_addr", 32'(seen_wr_addr), 32'h000123);
        check_output("write_data", 32'(seen_wr_data), 32'hBEEF);

        // Single read from p1.
        ret_data = 16'h1234;
        v0 = rvalid_cnt[0]; v1 = rvalid_cnt[1];
        @(posedge clk);
        q1.push_back(mk(1'b0, 24'h3FFFFF, 16'h0000));
        wait_done("read", 100);
        check_output("read_p1_rdata", 32'(p1_rdata), 32'h1234);
        check_output("read_p1_rvalids", rvalid_cnt[1] - v1, 32'd1);
        check_output("read_p0_rvalids", rvalid_cnt[0] - v0, 32'd0);
        check_output("read_p0_rdata", 32'(p0_rdata), 32'h0000);

        // Both ports request together right after reset, then keep requesting.
        apply_reset();
        ret_data = 16'h5A5A;
        logb = gnt_log.size();
        @(posedge clk);
        q0.push_back(mk(1'b1, 24'h000010, 16'h0A0A));
        q0.push_back(mk(1'b0, 24'h000011, 16'h0000));
        q0.push_back(mk(1'b1, 24'h000012, 16'h0C0C));
        q1.push_back(mk(1'b1, 24'h100000, 16'h1111));
        q1.push_back(mk(1'b1, 24'h100001, 16'h2222));
        q1.push_back(mk(1'b0, 24'h100002, 16'h0000));
        wait_done("contention", 400);
        check_output("contention_grants", gnt_log.size() - logb, 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (logb + i < gnt_log.size())
                check_output($sformatf("contention_order_%0d", i), gnt_log[logb + i], exp_order[i]);
        end
        check_output("contention_p0_rdata", 32'(p0_rdata), 32'h5A5A);
        check_output("contention_p1_rdata", 32'(p1_rdata), 32'h5A5A);

        // Refresh stall: busy held low for 12 cycles after the enable appears.
        stall_cycles = 12;
        acc = cmds_accepted; g0 = gnt_cnt[0]; we0 = wr_en_cycles;
        @(posedge clk);
        q0.push_back(mk(1'b1, 24'h0ABCDE, 16'h7777));
        wait_done("stall", 200);
        check_output("stall_accepted", cmds_accepted - acc, 32'd1);
        check_output("stall_p0_gnts", gnt_cnt[0] - g0, 32'd1);
        check_output("stall_wr_cycles", wr_en_cycles - we0, 32'd13);
        stall_cycles = 0;

        // Reset while a read is in its busy phase; the late rd_ready must be dropped.
        busy_len = 10;
        rd_at = 7;
        ret_data = 16'hCAFE;
        v0 = rvalid_cnt[0]; v1 = rvalid_cnt[1]; rp = rd_pulses;
        @(posedge clk);
        q0.push_back(mk(1'b0, 24'h000456, 16'h0000));
        n = 0;
        saw = 0;
        while (n < 100 && !(saw && !rd_enable)) begin
            @(posedge clk);
            #1;
            if (rd_enable) saw = 1;
            n++;
        end
        check_output("abort_reached_active", {31'd0, saw && !rd_enable}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_async");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 50 && ctrl_run) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        check_output("abort_rd_ready_seen", rd_pulses - rp, 32'd1);
        check_output("abort_p0_rvalids", rvalid_cnt[0] - v0, 32'd0);
        check_output("abort_p1_rvalids", rvalid_cnt[1] - v1, 32'd0);
        check_output("abort_p0_rdata", 32'(p0_rdata), 32'h0000);
        busy_len = 3;
        rd_at = 2;
    endtask

    initial begin
        apply_stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
